// File: rtl/lsu32.sv
// RV32I load/store unit: one outstanding request, byte-lane steering, load extension and access timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses report an error instead of being aligned down.
module lsu32 #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] daddr,
   output logic [31:0] dwdata,
   output logic [3:0]  dwe,
   output logic        dre,
   input  logic        dready,
   input  logic [31:0] drdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [31:0] LP_CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_next;
   logic        r_rdy;
   logic [31:0] r_cnt;
   logic        r_err;
   logic        r_store;
   logic [2:0]  r_f3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_accept, w_legal, w_f3_ok, w_mis, w_timeout;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wlane;
   logic [31:0] w_rshift;

   function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  f_load_ext = {{24{w[7]}}, w[7:0]};
         3'b001:  f_load_ext = {{16{w[15]}}, w[15:0]};
         3'b100:  f_load_ext = {24'd0, w[7:0]};
         3'b101:  f_load_ext = {16'd0, w[15:0]};
         default: f_load_ext = w;
      endcase
   endfunction

   assign w_accept  = req_valid & req_ready;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_CNT_LAST);

   always_comb begin
      w_f3_ok = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = ~is_store;
         default:                w_f3_ok = 1'b0;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      w_mis = ((funct3[1:0] == 2'b01) && addr[0]) || ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
      w_mis = 1'b0;
`endif
      w_legal = w_f3_ok & ~w_mis;
   end

   // Misaligned H/W are aligned down by dropping the low address bits from the lane offset
   always_comb begin
      case (r_f3[1:0])
         2'b00: begin
            w_off   = r_addr[1:0];
            w_be    = 4'b0001 << r_addr[1:0];
            w_wlane = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_off   = {r_addr[1], 1'b0};
            w_be    = 4'b0011 << {r_addr[1], 1'b0};
            w_wlane = {2{r_wdata[15:0]}};
         end
         default: begin
            w_off   = 2'b00;
            w_be    = 4'b1111;
            w_wlane = r_wdata;
         end
      endcase
      w_rshift = drdata >> {w_off, 3'b000};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = w_legal ? S_ACCESS : S_RESP;
         S_ACCESS: if (dready || w_timeout) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // r_rdy holds req_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdy <= 1'b0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_accept) begin
            r_err <= ~w_legal;
            r_cnt <= '0;
         end else if (r_state == S_ACCESS) begin
            if (dready)         r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
            else                r_cnt <= r_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_store <= is_store;
         r_f3    <= funct3;
         r_addr  <= addr;
         r_wdata <= wdata;
      end
      if ((r_state == S_ACCESS) && dready) r_rdata <= f_load_ext(r_f3, w_rshift);
   end

   always_comb begin
      req_ready  = 1'b0;
      daddr      = '0;
      dwdata     = '0;
      dwe        = '0;
      dre        = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_err   = 1'b0;
      case (r_state)
         S_IDLE:   req_ready = r_rdy;
         S_ACCESS: begin
            daddr = {r_addr[31:2], 2'b00};
            if (r_store) begin
               dwe    = w_be;
               dwdata = w_wlane;
            end else begin
               dre = 1'b1;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            resp_data  = (r_err || r_store) ? 32'd0 : r_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu32.sv
// Directed testbench for lsu32 built with TIMEOUT_CYCLES=4.
module tb_lsu32;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, daddr, dwdata, drdata, resp_data;
   logic [3:0]  dwe;
   logic        dre, dready, resp_valid, resp_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lsu32 #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
      .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .dre(dre), .dready(dready),
      .drdata(drdata), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
   );

   // Presents a request and returns #1 after its acceptance edge
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else n_pass++;
      n_total++; if ({dre, dwe, resp_valid, resp_err} !== 7'd0) $display("FAIL rst_strobes got %b want 0", {dre, dwe, resp_valid, resp_err}); else n_pass++;
      n_total++; if (daddr !== 32'd0) $display("FAIL rst_daddr got %h want 0", daddr); else n_pass++;
      reset = 1'b1;
      #1;
      n_total++; if (req_ready !== 1'b0) $display("FAIL rel_ready_early got %b want 0", req_ready); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (req_ready !== 1'b1) $display("FAIL rel_ready got %b want 1", req_ready); else n_pass++;
   endtask

   task automatic test_store_word;
      dready = 1'b1;
      issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
      n_total++; if (daddr !== 32'h104) $display("FAIL sw_daddr got %h want 00000104", daddr); else n_pass++;
      n_total++; if (dwe !== 4'b1111) $display("FAIL sw_dwe got %b want 1111", dwe); else n_pass++;
      n_total++; if (dwdata !== 32'hDEADBEEF) $display("FAIL sw_dwdata got %h want deadbeef", dwdata); else n_pass++;
      n_total++; if ({dre, req_ready, resp_valid} !== 3'b000) $display("FAIL sw_access_ctl got %b want 000", {dre, req_ready, resp_valid}); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL sw_resp got %b want 10", {resp_valid, resp_err}); else n_pass++;
      n_total++; if ({dwe, resp_data} !== 36'd0) $display("FAIL sw_resp_data got %h want 0", {dwe, resp_data}); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL sw_idle got %b want 01", {resp_valid, req_ready}); else n_pass++;
      dready = 1'b0;
   endtask

   task automatic test_loads;
      logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [31:0] ad [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h100, 32'h200};
      logic [31:0] rd [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h12345678, 32'h0000007F};
      logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h12345678, 32'h0000007F};
      for (int i = 0; i < 6; i++) begin
         dready = 1'b1; drdata = rd[i];
         issue(1'b0, f3[i], ad[i], 32'h0);
         n_total++; if ({dre, dwe} !== 5'b10000) $display("FAIL ld%0d_strobe got %b want 10000", i, {dre, dwe}); else n_pass++;
         n_total++; if (daddr !== (ad[i] & 32'hFFFFFFFC)) $display("FAIL ld%0d_daddr got %h want %h", i, daddr, ad[i] & 32'hFFFFFFFC); else n_pass++;
         @(posedge clk); #1;
         n_total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL ld%0d_resp got %b want 10", i, {resp_valid, resp_err}); else n_pass++;
         n_total++; if (resp_data !== ex[i]) $display("FAIL ld%0d_data got %h want %h", i, resp_data, ex[i]); else n_pass++;
         @(posedge clk); #1;
      end
      dready = 1'b0;
   endtask

   task automatic test_store_lanes;
      logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b000};
      logic [31:0] ad [3] = '{32'h11, 32'h12, 32'h13};
      logic [31:0] wd [3] = '{32'h000000AB, 32'h1234CAFE, 32'h00000055};
      logic [3:0]  be [3] = '{4'b0010, 4'b1100, 4'b1000};
      logic [31:0] ln [3] = '{32'hABABABAB, 32'hCAFECAFE, 32'h55555555};
      for (int i = 0; i < 3; i++) begin
         dready = 1'b1;
         issue(1'b1, f3[i], ad[i], wd[i]);
         n_total++; if (dwe !== be[i]) $display("FAIL st%0d_dwe got %b want %b", i, dwe, be[i]); else n_pass++;
         n_total++; if (dwdata !== ln[i]) $display("FAIL st%0d_dwdata got %h want %h", i, dwdata, ln[i]); else n_pass++;
         n_total++; if (daddr !== 32'h10) $display("FAIL st%0d_daddr got %h want 00000010", i, daddr); else n_pass++;
         @(posedge clk); #1;
         n_total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL st%0d_resp got %b want 10", i, {resp_valid, resp_err}); else n_pass++;
         @(posedge clk); #1;
      end
      dready = 1'b0;
   endtask

   task automatic test_misalign;
      dready = 1'b1; drdata = 32'h11223344;
      issue(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      n_total++; if (dre !== 1'b0) $display("FAIL mis_lw_dre got %b want 0", dre); else n_pass++;
      n_total++; if ({resp_valid, resp_err} !== 2'b11) $display("FAIL mis_lw_resp got %b want 11", {resp_valid, resp_err}); else n_pass++;
      n_total++; if (resp_data !== 32'd0) $display("FAIL mis_lw_data got %h want 0", resp_data); else n_pass++;
      @(posedge clk); #1;
`else
      n_total++; if ({dre, daddr} !== {1'b1, 32'h100}) $display("FAIL mis_lw_access got %b/%h want 1/00000100", dre, daddr); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL mis_lw_resp got %b want 10", {resp_valid, resp_err}); else n_pass++;
      n_total++; if (resp_data !== 32'h11223344) $display("FAIL mis_lw_data got %h want 11223344", resp_data); else n_pass++;
      @(posedge clk); #1;
      drdata = 32'hBEEF0000;
      issue(1'b0, 3'b001, 32'h203, 32'h0);
      @(posedge clk); #1;
      n_total++; if (resp_data !== 32'hFFFFBEEF) $display("FAIL mis_lh_data got %h want ffffbeef", resp_data); else n_pass++;
      @(posedge clk); #1;
      issue(1'b1, 3'b001, 32'h1, 32'h0000A5A5);
      n_total++; if ({dwe, dwdata} !== {4'b0011, 32'hA5A5A5A5}) $display("FAIL mis_sh_lane got %b/%h want 0011/a5a5a5a5", dwe, dwdata); else n_pass++;
      @(posedge clk); #1;
      @(posedge clk); #1;
`endif
      dready = 1'b0;
   endtask

   task automatic test_illegal;
      issue(1'b0, 3'b011, 32'h40, 32'h0);
      n_total++; if ({resp_valid, resp_err, dre} !== 3'b110) $display("FAIL ill_ld got %b want 110", {resp_valid, resp_err, dre}); else n_pass++;
      n_total++; if (resp_data !== 32'd0) $display("FAIL ill_ld_data got %h want 0", resp_data); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL ill_ld_idle got %b want 01", {resp_valid, req_ready}); else n_pass++;
      issue(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF);
      n_total++; if ({resp_valid, resp_err, dwe} !== 6'b110000) $display("FAIL ill_st got %b want 110000", {resp_valid, resp_err, dwe}); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_timeout;
      dready = 1'b0; drdata = 32'hFFFFFFFF;
      issue(1'b0, 3'b010, 32'h40, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n_total++; if ({dre, resp_valid} !== 2'b10) $display("FAIL to_wait%0d got %b want 10", i, {dre, resp_valid}); else n_pass++;
         @(posedge clk); #1;
      end
      n_total++; if (dre !== 1'b1) $display("FAIL to_4th_dre got %b want 1", dre); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, resp_err, dre} !== 3'b110) $display("FAIL to_resp got %b want 110", {resp_valid, resp_err, dre}); else n_pass++;
      n_total++; if (resp_data !== 32'd0) $display("FAIL to_data got %h want 0", resp_data); else n_pass++;
      @(posedge clk); #1;
      issue(1'b0, 3'b010, 32'h40, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      dready = 1'b1; drdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL to_race_resp got %b want 10", {resp_valid, resp_err}); else n_pass++;
      n_total++; if (resp_data !== 32'hCAFEF00D) $display("FAIL to_race_data got %h want cafef00d", resp_data); else n_pass++;
      dready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access;
      dready = 1'b0;
      issue(1'b1, 3'b010, 32'h80, 32'h12345678);
      n_total++; if (dwe !== 4'b1111) $display("FAIL rma_dwe_pre got %b want 1111", dwe); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_total++; if ({dwe, dre, req_ready} !== 6'd0) $display("FAIL rma_async got %b want 000000", {dwe, dre, req_ready}); else n_pass++;
      n_total++; if (daddr !== 32'd0) $display("FAIL rma_daddr got %h want 0", daddr); else n_pass++;
      dready = 1'b1;
      @(posedge clk); #1;
      n_total++; if (resp_valid !== 1'b0) $display("FAIL rma_no_resp got %b want 0", resp_valid); else n_pass++;
      reset = 1'b1;
      #1;
      n_total++; if (req_ready !== 1'b0) $display("FAIL rma_ready_early got %b want 0", req_ready); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL rma_ready got %b want 10", {req_ready, resp_valid}); else n_pass++;
      dready = 1'b0;
   endtask

   task automatic test_back_to_back;
      dready = 1'b1; drdata = 32'h01020304;
      issue(1'b0, 3'b010, 32'h8, 32'h0);
      req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'hC; wdata = 32'h55AA55AA;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, resp_data} !== {1'b1, 32'h01020304}) $display("FAIL b2b_ld got %b/%h want 1/01020304", resp_valid, resp_data); else n_pass++;
      n_total++; if (dwe !== 4'b0000) $display("FAIL b2b_ignored got %b want 0000", dwe); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (req_ready !== 1'b1) $display("FAIL b2b_idle got %b want 1", req_ready); else n_pass++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_total++; if ({dwe, daddr, dwdata} !== {4'b1111, 32'hC, 32'h55AA55AA}) $display("FAIL b2b_st got %b/%h/%h want 1111/0000000c/55aa55aa", dwe, daddr, dwdata); else n_pass++;
      @(posedge clk); #1;
      n_total++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL b2b_st_resp got %b want 10", {resp_valid, resp_err}); else n_pass++;
      dready = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; dready = 1'b0; drdata = '0;
      test_reset;
      test_store_word;
      test_loads;
      test_store_lanes;
      test_misalign;
      test_illegal;
      test_timeout;
      test_reset_mid_access;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/lsu32.md
LSU32 -- requirements
Module: lsu32

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles waiting for dready before error; 0 disables the timeout.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  block idle, can accept request.
REQ-006 is_store  input  1  1=store, 0=load.
REQ-007 funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  effective address from ALU rvout.
REQ-009 wdata  input  32  store data (rs2 value).
REQ-010 daddr  output  32  word-aligned memory address {addr[31:2],2'b00}.
REQ-011 dwdata  output  32  lane-replicated store data.
REQ-012 dwe  output  4  byte write enables.
REQ-013 dre  output  1  memory read strobe.
REQ-014 dready  input  1  memory completes access this cycle.
REQ-015 drdata  input  32  memory read word, valid when dready=1.
REQ-016 resp_valid  output  1  one-cycle completion pulse.
REQ-017 resp_data  output  32  extended load result; 0 for stores and errors.
REQ-018 resp_err  output  1  misaligned, illegal funct3, or timeout.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Accept on rising edge with req_valid=1 and req_ready=1; latch is_store, funct3, addr, wdata.
REQ-021 Legal funct3: loads {000,001,010,100,101}, stores {000,001,010}; others -> IDLE to RESP with resp_err=1, no memory strobe.
REQ-022 Legal request -> ACCESS; in ACCESS drive daddr, and dre=1 (load) or dwe per width (store); all strobes 0 outside ACCESS.
REQ-023 Store lanes: B dwe=4'b0001<<addr[1:0], dwdata={4{wdata[7:0]}}; H dwe=4'b0011<<addr[1:0], dwdata={2{wdata[15:0]}}; W dwe=4'b1111, dwdata=wdata.
REQ-024 Load: select byte/half at bit offset addr[1:0]*8 of drdata; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-025 dready=1 in ACCESS -> capture result, go RESP; resp_valid=1 for exactly the RESP cycle, then IDLE.
REQ-026 Minimum latency: acceptance edge E0, ACCESS cycle after E0, resp_valid high in cycle after E1 when dready=1 in first ACCESS cycle.
REQ-027 Timeout counter clears on entry to ACCESS, increments each ACCESS cycle without dready; reaching TIMEOUT_CYCLES -> RESP, resp_err=1, resp_data=0, strobes dropped.
REQ-028 dready ignored outside ACCESS; req_valid ignored outside IDLE (no queuing).
REQ-029 dready on the same cycle the counter reaches the limit SHALL win: normal completion, resp_err=0.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, counter 0, and all outputs 0 (including req_ready, dre, dwe, resp_valid).
REQ-031 req_ready SHALL rise on first rising clk edge after reset deasserts.
REQ-032 Reset during ACCESS SHALL abort the access with no response pulse.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: H at addr[0]=1 or W at addr[1:0]!=0 -> RESP with resp_err=1, no memory strobe.
REQ-034 Macro undefined: misaligned H/W SHALL clear low address bits (H: addr[0], W: addr[1:0]) and complete normally, resp_err=0.

Verification
REQ-035 SW addr=0x104, wdata=0xDEADBEEF, dready=1 at once -> daddr=0x104, dwe=1111, dwdata=0xDEADBEEF, resp_valid 2 cycles after acceptance, resp_err=0.
REQ-036 LB addr=0x203, drdata=0x80FF_0000 -> resp_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202 -> 0xFFFF80FF.
REQ-037 SB addr=0x11, wdata=0x000000AB -> dwe=0010, dwdata=0xABABABAB.
REQ-038 LW addr=0x102: with LSU_MISALIGN_TRAP_EN -> resp_err=1, dre never high; without -> daddr=0x100, normal completion.
REQ-039 TIMEOUT_CYCLES=4, dready held 0 -> resp_err=1, resp_data=0 after 4 ACCESS cycles; dready at 4th cycle -> normal completion.
REQ-040 reset=0 mid-ACCESS -> dre/dwe fall without clock, no resp_valid, req_ready=1 one edge after release.
